// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO blocks (write side, read side and
// the pointer synchronizer).
//
// Contents:
//   FIFO_ADDR_DEF  - default memory address width
//   FIFO_DEPTH_DEF - default FIFO depth (2^FIFO_ADDR_DEF)
//   FIFO_PTR_W_DEF - default pointer width (one extra wrap bit)
//   FIFO_AF_DEF    - default almost-full threshold
//   bin2gray       - binary to Gray, for any width up to FIFO_FN_W
//   gray2bin       - Gray to binary, for any width up to FIFO_FN_W
package fifo_pkg;

  localparam int FIFO_ADDR_DEF  = 4;
  localparam int FIFO_DEPTH_DEF = 1 << FIFO_ADDR_DEF;
  localparam int FIFO_PTR_W_DEF = FIFO_ADDR_DEF + 1;
  localparam int FIFO_AF_DEF    = 12;

  // The conversion helpers work on a 32-bit container. The width argument
  // selects how many low bits form the code word; bits above it are ignored.
  localparam int FIFO_FN_W = 32;

  function automatic logic [FIFO_FN_W-1:0] width_mask(input int unsigned w);
    logic [FIFO_FN_W-1:0] m;
    if (w >= FIFO_FN_W) m = '1;
    else                m = (FIFO_FN_W'(1) << w) - FIFO_FN_W'(1);
    return m;
  endfunction

  function automatic logic [FIFO_FN_W-1:0] bin2gray(input logic [FIFO_FN_W-1:0] b,
                                                    input int unsigned          w);
    logic [FIFO_FN_W-1:0] bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits from the MSB down to it.
  function automatic logic [FIFO_FN_W-1:0] gray2bin(input logic [FIFO_FN_W-1:0] g,
                                                    input int unsigned          w);
    logic [FIFO_FN_W-1:0] b;
    logic                 acc;
    b   = '0;
    acc = 1'b0;
    for (int i = FIFO_FN_W - 1; i >= 0; i--) begin
      if (i < int'(w)) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter, shared by the write-side full
// logic and the read-side empty/level logic.
//
// Parameters:
//   W      - code width (pointer width, ADDR+1 in the FIFO)
// Ports:
//   i_gray - Gray-coded input
//   o_bin  - binary equivalent (prefix XOR from the MSB)
module fifo_gray2bin
  import fifo_pkg::*;
#(
  parameter int W = FIFO_PTR_W_DEF
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign o_bin[gi] = ^i_gray[W-1:gi];
    end
  endgenerate

endmodule

// File: rtl/fifo_wr_ptr_full.sv
// Write-domain pointer and full-flag generator for the async FIFO.
//
// Parameters:
//   ADDR          - memory address width, depth is 2^ADDR (ADDR >= 2)
//   AF_THRESH     - almost-full level, 1 .. 2^ADDR
// Ports:
//   i_clk         - write-domain clock
//   i_rst_n       - asynchronous active-low reset
//   i_wr_inc      - push request for this cycle
//   i_clr_ovf     - clears the sticky overflow flag
//   i_rd_ptr_sync - Gray read pointer already synchronized into i_clk
//   o_wr_en       - memory write enable (combinational, push accepted)
//   o_wr_addr     - memory write address (registered binary pointer)
//   o_wr_ptr_gray - registered Gray write pointer for the read domain
//   o_full        - FIFO full (registered)
//   o_almost_full - fill level >= AF_THRESH (registered)
//   o_wr_level    - fill level seen from the write side, 0 .. 2^ADDR
//   o_overflow    - sticky: a push was attempted while full
module fifo_wr_ptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR      = FIFO_ADDR_DEF,
  parameter int AF_THRESH = FIFO_AF_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_wr_inc,
  input  logic            i_clr_ovf,
  input  logic [ADDR:0]   i_rd_ptr_sync,
  output logic            o_wr_en,
  output logic [ADDR-1:0] o_wr_addr,
  output logic [ADDR:0]   o_wr_ptr_gray,
  output logic            o_full,
  output logic            o_almost_full,
  output logic [ADDR:0]   o_wr_level,
  output logic            o_overflow
);

  localparam int            PW     = ADDR + 1;
  localparam logic [ADDR:0] AF_LVL = PW'(AF_THRESH);

  logic [ADDR:0] r_bin;
  logic [ADDR:0] r_gray;
  logic [ADDR:0] r_level;
  logic          r_full;
  logic          r_almost_full;
  logic          r_overflow;

  logic          w_push_ok;
  logic [ADDR:0] w_bin_next;
  logic [ADDR:0] w_gray_next;
  logic [ADDR:0] w_rd_full_cmp;
  logic [ADDR:0] w_rd_bin;
  logic [ADDR:0] w_level_next;
  logic          w_full_next;
  logic          w_overflow_next;

  assign w_push_ok   = i_wr_inc & ~r_full;
  assign w_bin_next  = r_bin + PW'(w_push_ok);
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

  // In Gray code, "write is exactly one lap ahead of read" means the two
  // MSBs differ and all lower bits match.
  assign w_rd_full_cmp = {~i_rd_ptr_sync[ADDR:ADDR-1], i_rd_ptr_sync[ADDR-2:0]};
  assign w_full_next   = (w_gray_next == w_rd_full_cmp);

  fifo_gray2bin #(
    .W (PW)
  ) u_rd_g2b (
    .i_gray (i_rd_ptr_sync),
    .o_bin  (w_rd_bin)
  );

  // Modulo 2^(ADDR+1) difference; the extra wrap bit keeps 2^ADDR distinct
  // from 0. The read pointer is stale, so the level can only be overstated.
  assign w_level_next = w_bin_next - w_rd_bin;

  // A new overflow outranks a clear in the same cycle.
  assign w_overflow_next = (i_wr_inc & r_full) | (r_overflow & ~i_clr_ovf);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bin         <= '0;
      r_gray        <= '0;
      r_level       <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_bin         <= w_bin_next;
      r_gray        <= w_gray_next;
      r_level       <= w_level_next;
      r_full        <= w_full_next;
      r_almost_full <= (w_level_next >= AF_LVL);
      r_overflow    <= w_overflow_next;
    end
  end

  assign o_wr_en       = w_push_ok;
  assign o_wr_addr     = r_bin[ADDR-1:0];
  assign o_wr_ptr_gray = r_gray;
  assign o_full        = r_full;
  assign o_almost_full = r_almost_full;
  assign o_wr_level    = r_level;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
module tb_fifo_wr_ptr_full;
  import fifo_pkg::*;

  localparam int ADDR  = 4;
  localparam int DEPTH = 16;
  localparam int AFT   = 12;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_wr_inc = 1'b0;
  logic            i_clr_ovf = 1'b0;
  logic [ADDR:0]   i_rd_ptr_sync = '0;
  logic            o_wr_en;
  logic [ADDR-1:0] o_wr_addr;
  logic [ADDR:0]   o_wr_ptr_gray;
  logic            o_full;
  logic            o_almost_full;
  logic [ADDR:0]   o_wr_level;
  logic            o_overflow;

  always #5 i_clk = ~i_clk;

  fifo_wr_ptr_full #(
    .ADDR      (ADDR),
    .AF_THRESH (AFT)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_wr_inc      (i_wr_inc),
    .i_clr_ovf     (i_clr_ovf),
    .i_rd_ptr_sync (i_rd_ptr_sync),
    .o_wr_en       (o_wr_en),
    .o_wr_addr     (o_wr_addr),
    .o_wr_ptr_gray (o_wr_ptr_gray),
    .o_full        (o_full),
    .o_almost_full (o_almost_full),
    .o_wr_level    (o_wr_level),
    .o_overflow    (o_overflow)
  );

  typedef struct packed {
    logic       wr_en;
    logic [3:0] addr;
    logic [4:0] gray;
    logic       full;
    logic       af;
    logic [4:0] level;
    logic       ovf;
  } snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: counts of accepted pushes and of reads.
  int m_w;
  int m_r;
  bit m_full;
  bit m_ovf;

  function automatic logic [4:0] gray_of(input int n);
    logic [31:0] g;
    g = bin2gray(32'(n % 32), 5);
    return g[4:0];
  endfunction

  task automatic model_reset();
    m_w = 0; m_r = 0; m_full = 1'b0; m_ovf = 1'b0;
  endtask

  // Drives one clock cycle, records expected and observed snapshots.
  task automatic cycle(input bit inc, input bit clr, input int rcnt);
    snap_t e;
    snap_t o;
    int    lvl;
    bit    ok;
    i_wr_inc      = inc;
    i_clr_ovf     = clr;
    i_rd_ptr_sync = gray_of(rcnt);
    #1;
    o = '0;
    o.wr_en = o_wr_en;
    o.addr  = o_wr_addr;
    ok      = inc && !m_full;
    e       = '0;
    e.wr_en = ok;
    e.addr  = 4'(m_w % DEPTH);
    m_ovf   = (inc && m_full) || (m_ovf && !clr);
    if (ok) m_w++;
    m_r     = rcnt;
    lvl     = m_w - m_r;
    m_full  = (lvl == DEPTH);
    e.gray  = gray_of(m_w);
    e.level = 5'(lvl);
    e.full  = m_full;
    e.af    = (lvl >= AFT);
    e.ovf   = m_ovf;
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    o.gray  = o_wr_ptr_gray;
    o.full  = o_full;
    o.af    = o_almost_full;
    o.level = o_wr_level;
    o.ovf   = o_overflow;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    snap_t e;
    snap_t o;
    int    k;
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    n_checks++;
    if ({o_wr_en, o_wr_addr, o_wr_ptr_gray, o_full, o_almost_full, o_wr_level, o_overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got gray=%b full=%b af=%b lvl=%0d ovf=%b addr=%0d, want all 0",
               o_wr_ptr_gray, o_full, o_almost_full, o_wr_level, o_overflow, o_wr_addr);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
    repeat (2) cycle(1'b0, 1'b0, 0);
    repeat (3) cycle(1'b1, 1'b0, 0);
    // Reset in the middle of a cycle, away from any clock edge.
    i_wr_inc = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_wr_ptr_gray !== 5'd0 || o_wr_level !== 5'd0 || o_wr_addr !== 4'd0 ||
        o_full !== 1'b0 || o_almost_full !== 1'b0 || o_overflow !== 1'b0 || o_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got gray=%b lvl=%0d addr=%0d full=%b ovf=%b, want all 0",
               o_wr_ptr_gray, o_wr_level, o_wr_addr, o_full, o_overflow);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
    repeat (3) cycle(1'b0, 1'b0, 0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      $display("txn reset[%0d] got %p", k, o);
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %p want %p", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_fill();
    snap_t e;
    snap_t o;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      $display("txn fill[%0d] got %p", i, o);
      if (o !== e) begin
        n_fail++;
        $display("FAIL fill[%0d]: got %p want %p", i, o, e);
      end
    end
    n_checks++;
    if (o_full !== 1'b1 || o_wr_ptr_gray !== 5'b11000 || o_wr_level !== 5'd16) begin
      n_fail++;
      $display("FAIL fill_end: got full=%b gray=%b lvl=%0d, want full=1 gray=11000 lvl=16",
               o_full, o_wr_ptr_gray, o_wr_level);
    end
  endtask

  task automatic test_overflow();
    snap_t e;
    snap_t o;
    cycle(1'b1, 1'b0, 0);   // refused push, overflow sets
    cycle(1'b0, 1'b1, 0);   // clear
    cycle(1'b1, 1'b1, 0);   // set and clear together: set wins
    cycle(1'b0, 1'b1, 0);   // clear again
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      $display("txn ovf[%0d] got %p", i, o);
      if (o !== e) begin
        n_fail++;
        $display("FAIL ovf[%0d]: got %p want %p", i, o, e);
      end
    end
  endtask

  task automatic test_drain();
    snap_t e;
    snap_t o;
    cycle(1'b0, 1'b0, 1);   // one read seen: full drops, level 15
    n_checks++;
    if (o_full !== 1'b0 || o_wr_level !== 5'd15) begin
      n_fail++;
      $display("FAIL drain_release: got full=%b lvl=%0d, want full=0 lvl=15", o_full, o_wr_level);
    end
    cycle(1'b1, 1'b0, 1);   // accepted, full again
    cycle(1'b1, 1'b0, 2);   // push + read advance while full: refused
    cycle(1'b0, 1'b1, 2);   // clear the overflow that refusal raised
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      $display("txn drain[%0d] got %p", i, o);
      if (o !== e) begin
        n_fail++;
        $display("FAIL drain[%0d]: got %p want %p", i, o, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    snap_t e;
    snap_t o;
    cycle(1'b1, 1'b0, 3);   // level 15 -> push and read together
    e = exp_q.pop_front();
    o = obs_q.pop_front();
    n_checks++;
    $display("txn simul got %p", o);
    if (o !== e) begin
      n_fail++;
      $display("FAIL simul: got %p want %p", o, e);
    end
    n_checks++;
    if (o_wr_level !== 5'd15 || o_full !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_level: got lvl=%0d full=%b, want lvl=15 full=0", o_wr_level, o_full);
    end
  endtask

  task automatic test_wrap();
    snap_t      e;
    snap_t      o;
    int         h0;
    int         h1;
    logic [4:0] prev;
    bit         wrapped;
    h0 = m_w;
    h1 = m_w;
    prev = gray_of(m_w);
    wrapped = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b0, h0);
      h0 = h1;
      h1 = m_w;
    end
    for (int i = 0; i < 40; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      $display("txn wrap[%0d] got %p", i, o);
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %p want %p", i, o, e);
      end
      n_checks++;
      if ($countones(o.gray ^ prev) != 1 || o.full !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_step[%0d]: gray %b -> %b full=%b, want one bit flip and full=0",
                 i, prev, o.gray, o.full);
      end
      if (prev == 5'b10000 && o.gray == 5'b00000) wrapped = 1'b1;
      prev = e.gray;
    end
    n_checks++;
    if (wrapped !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_seen: got %b want 1", wrapped);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_simultaneous();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
